mc_writeback_scoreboard: RTL

- Producer-side counterpart of EXE operand forwarding. Tracks destination registers of in-flight multi-cycle ops (integer div/rem, FP div/sqrt) that cannot be forwarded from MEM/WB.
- ID consults it to stall dependent instructions.
- Separate busy maps for the general (x) and FP (f) register files, mirroring the gen/fp select scheme used by forwarding.
- Sits beside the ID/EXE hazard logic; updated by the multi-cycle unit's issue and completion ports.

---
 rtl/mc_writeback_scoreboard.sv | 119 +++++++++++
 1 files changed

// File: rtl/mc_writeback_scoreboard.sv
// Busy-register scoreboard for in-flight multi-cycle ops (div/rem, FP div/sqrt), split into x and f maps.
// Optional SB_CMP_BYPASS_EN: a register completing this cycle is already treated as not busy.
module mc_writeback_scoreboard #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd_addr,
  input  logic             iss_fp,
  output logic             iss_ready,
  input  logic             iss_flush,
  input  logic             cmp_valid,
  input  logic [4:0]       cmp_rd_addr,
  input  logic             cmp_fp,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_fp,
  input  logic             id_rs2_fp,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  output logic             id_stall,
  output logic [CNT_W-1:0] inflight_cnt,
  output logic             sb_err
);

  logic [31:0]      gen_busy;
  logic [31:0]      fp_busy;
  logic [31:0]      gen_busy_nxt;
  logic [31:0]      fp_busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             acc;
  logic             set_en;
  logic             iss_x0;
  logic             cmp_x0;
  logic             cmp_busy;
  logic             cmp_ok;
  logic             cmp_bad;
  logic             target_busy;
  logic             rs1_busy;
  logic             rs2_busy;

  // General x0 is hardwired zero and therefore never pending.
  function automatic logic map_busy(input logic [31:0] gmap, input logic [31:0] fmap,
                                    input logic fp, input logic [4:0] addr);
    if (fp)
      return fmap[addr];
    return (addr != 5'd0) && gmap[addr];
  endfunction

  always_comb begin
    target_busy = map_busy(gen_busy, fp_busy, iss_fp, iss_rd_addr);
    rs1_busy    = map_busy(gen_busy, fp_busy, id_rs1_fp, id_rs1_addr);
    rs2_busy    = map_busy(gen_busy, fp_busy, id_rs2_fp, id_rs2_addr);
`ifdef SB_CMP_BYPASS_EN
    if (cmp_valid && (cmp_fp == iss_fp) && (cmp_rd_addr == iss_rd_addr))
      target_busy = 1'b0;
    if (cmp_valid && (cmp_fp == id_rs1_fp) && (cmp_rd_addr == id_rs1_addr))
      rs1_busy = 1'b0;
    if (cmp_valid && (cmp_fp == id_rs2_fp) && (cmp_rd_addr == id_rs2_addr))
      rs2_busy = 1'b0;
`endif
  end

  assign iss_ready = (inflight_cnt < CNT_W'(DEPTH)) && !target_busy;
  assign id_stall  = (id_rs1_used && rs1_busy) || (id_rs2_used && rs2_busy);

  assign acc      = iss_valid && iss_ready && !iss_flush;
  assign iss_x0   = !iss_fp && (iss_rd_addr == 5'd0);
  assign cmp_x0   = !cmp_fp && (cmp_rd_addr == 5'd0);
  assign set_en   = acc && !iss_x0;
  // Completion validity always looks at the registered map, never the bypass view.
  assign cmp_busy = map_busy(gen_busy, fp_busy, cmp_fp, cmp_rd_addr);
  assign cmp_ok   = cmp_valid && !cmp_x0 && cmp_busy;
  assign cmp_bad  = cmp_valid && !cmp_x0 && !cmp_busy;

  // Clear before set so a bypassed re-issue of the completing register stays busy.
  always_comb begin
    gen_busy_nxt = gen_busy;
    fp_busy_nxt  = fp_busy;
    if (cmp_ok) begin
      if (cmp_fp)
        fp_busy_nxt[cmp_rd_addr] = 1'b0;
      else
        gen_busy_nxt[cmp_rd_addr] = 1'b0;
    end
    if (set_en) begin
      if (iss_fp)
        fp_busy_nxt[iss_rd_addr] = 1'b1;
      else
        gen_busy_nxt[iss_rd_addr] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = inflight_cnt;
    if (set_en && !cmp_ok)
      cnt_nxt = inflight_cnt + CNT_W'(1);
    else if (cmp_ok && !set_en)
      cnt_nxt = inflight_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_busy     <= '0;
      fp_busy      <= '0;
      inflight_cnt <= '0;
      sb_err       <= 1'b0;
    end else begin
      gen_busy     <= gen_busy_nxt;
      fp_busy      <= fp_busy_nxt;
      inflight_cnt <= cnt_nxt;
      if (cmp_bad)
        sb_err <= 1'b1;
    end
  end

endmodule
